// File: rtl/confirm_input_ctrl_pkg.sv
// Shared types and constants for the confirm-button input conditioner.
package confirm_input_ctrl_pkg;

   localparam int ISA_WIDTH      = 32;
   localparam int CONF_CNT_WIDTH = 24;

   typedef enum logic [1:0] {
      CONF_IDLE     = 2'd0,
      CONF_PRESS_DB = 2'd1,
      CONF_HELD     = 2'd2,
      CONF_REL_DB   = 2'd3
   } conf_state_e;

   function automatic logic [CONF_CNT_WIDTH-1:0] cnt_last(input int cycles);
      return CONF_CNT_WIDTH'(cycles - 1);
   endfunction

endpackage

// File: rtl/confirm_input_ctrl_if.sv
// Bundle between the board I/O and the confirm conditioner.
interface confirm_input_ctrl_if #(
   parameter int SW_WIDTH = 16
);
   import confirm_input_ctrl_pkg::*;

   logic                 button_raw;
   logic [SW_WIDTH-1:0]  switch_raw;
   logic                 io_read;
   logic                 confirm_button;
   logic [ISA_WIDTH-1:0] io_rdata;
   logic                 pending;
   logic [7:0]           press_count;

   modport master (
      output button_raw,
      output switch_raw,
      output io_read,
      input  confirm_button,
      input  io_rdata,
      input  pending,
      input  press_count
   );

   modport slave (
      input  button_raw,
      input  switch_raw,
      input  io_read,
      output confirm_button,
      output io_rdata,
      output pending,
      output press_count
   );

endinterface

// File: rtl/confirm_input_ctrl_sync_2ff.sv
// Two-flop synchroniser with a configurable reset value.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/confirm_input_ctrl.sv
// Debounced confirm button with switch snapshot for the IORead stall.
module confirm_input_ctrl
   import confirm_input_ctrl_pkg::*;
#(
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   confirm_input_ctrl_if.slave  bus
);

   localparam logic [CONF_CNT_WIDTH-1:0] CntLast = cnt_last(DEBOUNCE_CYCLES);

   logic                 btn_s;
   logic [SW_WIDTH-1:0]  sw_s;
   conf_state_e          state_q;
   logic [CONF_CNT_WIDTH-1:0] cnt_q;
   logic                 confirm_q;
   logic [ISA_WIDTH-1:0] rdata_q;
   logic [7:0]           count_q;

   // Button syncs as pressed so a button held through reset is ignored.
   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync_btn (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (bus.button_raw),
      .q_o     (btn_s)
   );

   sync_2ff #(
      .WIDTH   (SW_WIDTH),
      .RST_VAL ('0)
   ) u_sync_sw (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (bus.switch_raw),
      .q_o     (sw_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= CONF_REL_DB;
         cnt_q     <= '0;
         confirm_q <= 1'b0;
         rdata_q   <= '0;
         count_q   <= '0;
      end else begin
         unique case (state_q)
            CONF_IDLE: begin
               if (btn_s) begin
                  state_q <= CONF_PRESS_DB;
                  cnt_q   <= '0;
               end
            end
            CONF_PRESS_DB: begin
               if (!btn_s) begin
                  state_q <= CONF_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q   <= CONF_HELD;
                  cnt_q     <= '0;
                  confirm_q <= 1'b1;
                  rdata_q   <= ISA_WIDTH'(sw_s);
                  count_q   <= count_q + 8'd1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CONF_HELD: begin
               if (!btn_s) begin
                  state_q <= CONF_REL_DB;
                  cnt_q   <= '0;
               end
            end
            CONF_REL_DB: begin
               // Returning to HELD is a bounce: no recapture, no count.
               if (btn_s) begin
                  state_q <= CONF_HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q   <= CONF_IDLE;
                  cnt_q     <= '0;
                  confirm_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= CONF_REL_DB;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.confirm_button = confirm_q;
   assign bus.io_rdata       = rdata_q;
   assign bus.press_count    = count_q;
   assign bus.pending        = bus.io_read & ~confirm_q;

endmodule
